pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives per-stage hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and sequences the data-memory req/ack handshake with a timeout.
- Counts stall cycles for performance debug. Sits beside the pipeline registers; each register qualifies its update with its stall/bubble bit.

Parameters:
- TIMEOUT, 16, maximum dmem wait cycles before the access is aborted.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  rs address of the instruction in ID
- id_rt  in  5  rt address of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_is_load  in  1  instruction in EX is a load
- ex_wd  in  5  EX destination register
- ex_wreg  in  1  EX writes a register
- id_branch_taken  in  1  branch/jump resolved taken in ID
- mem_access  in  1  instruction in MEM is a load/store (aluop decoded)
- dmem_ack  in  1  data memory completes access this cycle
- dmem_req  out  1  request to data memory
- stall  out  5  hold bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
- bubble_id_ex  out  1  load ID/EX with a NOP (wreg=0, aluop=0)
- bubble_mem_wb  out  1  load MEM/WB with a NOP
- flush_if_id  out  1  clear IF/ID (squash the fetched instruction)
- mem_err  out  1  sticky: a dmem access timed out
- stall_cnt  out  CNT_W  saturating count of cycles with any stall bit set

Behaviour:
- Reset: FSM=IDLE, wait counter=0, mem_err=0, stall_cnt=0. While rst=1, all combinational outputs are forced to 0 (stall=0, bubbles=0, flush=0, dmem_req=0).
- FSM states: IDLE, WAIT, DONE.
- IDLE: if mem_access=1, assert dmem_req combinationally. If dmem_ack=1 in the same cycle, stay in IDLE (zero-wait access). Otherwise go to WAIT with counter=1.
- WAIT: dmem_req=1 and mem_busy=1. Each cycle without ack, counter increments.
  - dmem_ack=1 -> DONE.
  - counter==TIMEOUT with no ack -> set mem_err, drop dmem_req, go to DONE (access aborted; the write-back data is undefined but the pipeline advances).
- DONE: dmem_req=0, mem_busy=0, exactly one cycle, then IDLE. This gives the pipeline one advance cycle so the same MEM instruction is not re-issued.
- mem_busy is defined as (IDLE and mem_access and not dmem_ack) or WAIT.
- Load-use hazard: luh = ex_is_load & ex_wreg & (ex_wd!=0) & ((id_use_rs & id_rs==ex_wd) | (id_use_rt & id_rt==ex_wd)).
- Priority of outputs, highest first:
  1. mem_busy: stall=5'b01111, bubble_mem_wb=1, bubble_id_ex=0, flush_if_id=0. A pending load-use or branch waits until mem_busy clears.
  2. luh: stall=5'b00011, bubble_id_ex=1, flush_if_id=0. The branch is re-evaluated next cycle.
  3. id_branch_taken: stall=0, flush_if_id=1.
  4. Otherwise: all 0.
- All of the above are combinational from the inputs and the FSM state (zero-cycle latency to the pipeline registers).
- stall_cnt increments on each clock edge where stall!=0, and saturates at all-ones.
- mem_err clears only on rst.
- rst asserted mid-WAIT: FSM returns to IDLE the next edge and dmem_req drops immediately (forced 0 while rst=1).

Decomposition:
- Shared defines: stall bit indices (STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB), FSM state encodings, NOP aluop value 4'b0000. These go beside the existing RstEnable/WriteDisable definitions.
- One natural sub-module: hazard_detect, the combinational load-use comparator producing luh. The FSM and counters stay in pipe_ctrl.

Test Plan:
- Reset, then idle inputs -> all outputs 0, stall_cnt=0, mem_err=0.
- ex_is_load=1, ex_wreg=1, ex_wd=5, id_use_rs=1, id_rs=5 -> stall=00011, bubble_id_ex=1 for one cycle; with ex_wd=0 -> no stall.
- mem_access=1, dmem_ack rises 3 cycles later -> dmem_req high 4 cycles, stall=01111 and bubble_mem_wb=1 during those cycles, DONE for one cycle, stall_cnt=4.
- mem_access=1, no ack -> after 16 WAIT cycles mem_err=1, dmem_req=0, FSM passes through DONE to IDLE.
- id_branch_taken=1 with luh=1 -> stall asserted and flush_if_id=0. Next cycle, with luh clear -> flush_if_id=1.
- rst pulsed during WAIT -> dmem_req=0 in the rst cycle, FSM=IDLE, mem_err and stall_cnt cleared.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: reset/write
// polarities, stall bit indices, dmem handshake FSM states and NOP encoding.
package pipe_ctrl_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int unsigned STALL_W     = 5;
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned STALL_IDEX  = 2;
  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;

  localparam logic [3:0] NOP_ALUOP = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Hold mask covering the PC and every pipeline register up to stage 'last'.
  function automatic logic [STALL_W-1:0] stall_upto(input int unsigned last);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < STALL_W; i++) begin
      if (i <= last) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_MEM  = stall_upto(STALL_EXMEM);
  localparam logic [STALL_W-1:0] STALL_LUH  = stall_upto(STALL_IFID);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side hazard inputs, dmem handshake and per-stage hold/bubble
// controls. master = the controller, slave = pipeline registers / dmem.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               ex_is_load;
  logic [4:0]         ex_wd;
  logic               ex_wreg;
  logic               id_branch_taken;
  logic               mem_access;
  logic               dmem_ack;
  logic               dmem_req;
  logic [STALL_W-1:0] stall;
  logic               bubble_id_ex;
  logic               bubble_mem_wb;
  logic               flush_if_id;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_is_load, ex_wd, ex_wreg, id_branch_taken,
    input  mem_access, dmem_ack,
    output dmem_req, stall, bubble_id_ex, bubble_mem_wb, flush_if_id
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_is_load, ex_wd, ex_wreg, id_branch_taken,
    output mem_access, dmem_ack,
    input  dmem_req, stall, bubble_id_ex, bubble_mem_wb, flush_if_id
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load
// currently in EX has not yet produced. Register 0 never creates a hazard.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wd,
  input  logic       ex_wreg,
  output logic       luh
);
  logic load_writes;
  logic rs_match;
  logic rt_match;

  always_comb begin
    load_writes = ex_is_load & ex_wreg & (ex_wd != 5'd0);
    rs_match    = id_use_rs & (id_rs == ex_wd);
    rt_match    = id_use_rt & (id_rt == ex_wd);
    luh         = load_writes & (rs_match | rt_match);
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: dmem req/ack sequencing
// with timeout, load-use and branch priority, sticky error and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      pif,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  mem_state_e         state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               luh;
  logic               mem_busy;
  logic               dmem_req;
  logic [STALL_W-1:0] stall;
  logic               bubble_id_ex;
  logic               bubble_mem_wb;
  logic               flush_if_id;

  hazard_detect u_hazard_detect (
    .id_rs      (pif.id_rs),
    .id_rt      (pif.id_rt),
    .id_use_rs  (pif.id_use_rs),
    .id_use_rt  (pif.id_use_rt),
    .ex_is_load (pif.ex_is_load),
    .ex_wd      (pif.ex_wd),
    .ex_wreg    (pif.ex_wreg),
    .luh        (luh)
  );

  // dmem handshake: a zero-wait ack in IDLE never leaves IDLE; DONE grants
  // exactly one advance cycle so the MEM instruction is not re-issued.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    dmem_req  = 1'b0;
    mem_busy  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pif.mem_access) begin
          dmem_req = 1'b1;
          if (!pif.dmem_ack) begin
            mem_busy = 1'b1;
            state_d  = ST_WAIT;
            wcnt_d   = WCNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        mem_busy = 1'b1;
        if (pif.dmem_ack) begin
          state_d = ST_DONE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = ST_DONE;
          wcnt_d    = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase

    if (rst == RstEnable) begin
      dmem_req  = 1'b0;
      mem_busy  = 1'b0;
      state_d   = ST_IDLE;
      wcnt_d    = '0;
      mem_err_d = 1'b0;
    end
  end

  // A pending load-use or branch is held off until the memory access clears.
  always_comb begin
    stall         = STALL_NONE;
    bubble_id_ex  = 1'b0;
    bubble_mem_wb = 1'b0;
    flush_if_id   = 1'b0;

    if (rst != RstEnable) begin
      if (mem_busy) begin
        stall         = STALL_MEM;
        bubble_mem_wb = 1'b1;
      end else if (luh) begin
        stall        = STALL_LUH;
        bubble_id_ex = 1'b1;
      end else if (pif.id_branch_taken) begin
        flush_if_id = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst == RstEnable) begin
      stall_cnt_d = '0;
    end else if ((stall != STALL_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wcnt_q      <= wcnt_d;
    mem_err_q   <= mem_err_d;
    stall_cnt_q <= stall_cnt_d;
  end

  always_comb begin
    pif.dmem_req      = dmem_req;
    pif.stall         = stall;
    pif.bubble_id_ex  = bubble_id_ex;
    pif.bubble_mem_wb = bubble_mem_wb;
    pif.flush_if_id   = flush_if_id;
    mem_err           = mem_err_q;
    stall_cnt         = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then weighted random
// traffic, checked against a cycle-level model of the stall rules.
module tb_pipe_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pif       (pif),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ma, ack, br, ld, wreg, urs, urt;
    logic [4:0] rs, rt, wd;
  } stim_t;

  typedef struct {
    logic [4:0]  stall;
    logic        bid, bmw, fl, req, err;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   push_en = 1'b0;

  // Model: cycles already spent waiting on dmem (0 = no access outstanding),
  // whether the previous cycle finished an access, sticky error, stall count.
  int unsigned m_wait = 0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  int unsigned m_cnt  = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst:1'b0, ma:1'b0, ack:1'b0, br:1'b0, ld:1'b0, wreg:1'b0,
          urs:1'b0, urt:1'b0, rs:5'd0, rt:5'd0, wd:5'd0};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit   luh, busy, outstanding;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    pif.mem_access      = s.ma;
    pif.dmem_ack        = s.ack;
    pif.id_branch_taken = s.br;
    pif.ex_is_load      = s.ld;
    pif.ex_wreg         = s.wreg;
    pif.id_use_rs       = s.urs;
    pif.id_use_rt       = s.urt;
    pif.id_rs           = s.rs;
    pif.id_rt           = s.rt;
    pif.ex_wd           = s.wd;

    e = '{stall:5'b0, bid:1'b0, bmw:1'b0, fl:1'b0, req:1'b0, err:m_err, cnt:m_cnt};
    if (!s.rst) begin
      luh = s.ld && s.wreg && (s.wd != 0) &&
            ((s.urs && s.rs == s.wd) || (s.urt && s.rt == s.wd));
      outstanding = (m_wait > 0);
      busy  = outstanding || (!m_done && s.ma && !s.ack);
      e.req = outstanding || (!m_done && s.ma);
      if (busy) begin
        e.stall = 5'b01111;
        e.bmw   = 1'b1;
      end else if (luh) begin
        e.stall = 5'b00011;
        e.bid   = 1'b1;
      end else if (s.br) begin
        e.fl = 1'b1;
      end
    end
    if (push_en) q.push_back(e);

    if (s.rst) begin
      m_wait = 0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (e.stall != 0 && m_cnt < CNT_MAX) m_cnt++;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_wait > 0) begin
        if (s.ack) begin
          m_wait = 0; m_done = 1'b1;
        end else if (m_wait == TIMEOUT) begin
          m_wait = 0; m_done = 1'b1; m_err = 1'b1;
        end else begin
          m_wait++;
        end
      end else if (s.ma && !s.ack) begin
        m_wait = 1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",         32'(pif.stall),         32'(e.stall));
        chk("bubble_id_ex",  32'(pif.bubble_id_ex),  32'(e.bid));
        chk("bubble_mem_wb", 32'(pif.bubble_mem_wb), 32'(e.bmw));
        chk("flush_if_id",   32'(pif.flush_if_id),   32'(e.fl));
        chk("dmem_req",      32'(pif.dmem_req),      32'(e.req));
        chk("mem_err",       32'(mem_err),           32'(e.err));
        chk("stall_cnt",     32'(stall_cnt),         e.cnt);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    noack;

    s = idle();
    s.rst = 1'b1;
    step(s);
    push_en = 1'b1;
    step(s);
    step(idle());
    step(idle());

    // load-use on rs, then the same with $zero as destination
    s = idle();
    s.ld = 1'b1; s.wreg = 1'b1; s.wd = 5'd5; s.urs = 1'b1; s.rs = 5'd5;
    step(s);
    s.wd = 5'd0; s.rs = 5'd0;
    step(s);

    // access acked on the fourth request cycle, then the DONE cycle
    s = idle();
    s.ma = 1'b1;
    for (int i = 0; i < 3; i++) step(s);
    s.ack = 1'b1;
    step(s);
    s.ack = 1'b0;
    step(s);
    step(idle());

    // zero-wait access
    s = idle(); s.ma = 1'b1; s.ack = 1'b1;
    step(s);
    step(idle());

    // timeout: 1 IDLE + 16 WAIT + DONE with mem_access held
    s = idle(); s.ma = 1'b1;
    for (int i = 0; i < 2 + int'(TIMEOUT); i++) step(s);
    step(idle());

    // branch competing with load-use, then alone
    s = idle();
    s.br = 1'b1; s.ld = 1'b1; s.wreg = 1'b1; s.wd = 5'd7; s.urt = 1'b1; s.rt = 5'd7;
    step(s);
    s = idle(); s.br = 1'b1;
    step(s);

    // reset mid-WAIT
    s = idle(); s.ma = 1'b1;
    for (int i = 0; i < 5; i++) step(s);
    s.rst = 1'b1;
    step(s);
    step(idle());
    step(idle());

    noack = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) noack = 40;
      s.rst  = ($urandom_range(0, 299) == 0);
      s.ma   = ($urandom_range(0, 2) == 0);
      s.ack  = (noack > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 3) == 0);
      s.ld   = $urandom_range(0, 1) != 0;
      s.wreg = $urandom_range(0, 3) != 0;
      s.urs  = $urandom_range(0, 1) != 0;
      s.urt  = $urandom_range(0, 1) != 0;
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.wd   = 5'($urandom_range(0, 3));
      step(s);
      if (noack > 0) noack--;
    end

    step(idle());
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
